// File: rtl/exec_pkg.sv
// exec_pkg: shared encodings for the execute-stage ALU and multiply/divide unit.
//   alu_op_e   - 4-bit ALU operation select (codes 12-15 are undefined, R = 0)
//   md_op_e    - 3-bit multiply/divide operation select (7 is reserved, acts as NONE)
//   md_state_e - multiply/divide controller state
package exec_pkg;

  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned MD_OP_W  = 3;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;

  typedef enum logic [MD_OP_W-1:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

endpackage

// File: rtl/exec_alu_if.sv
// exec_alu_if: operand/result bundle between the pipeline and exec_alu.
//   A, B, aluOp, mdOp, start : driven by the pipeline (master)
//   R, zero, busy, hi, lo    : driven by exec_alu (slave)
//   ovf                      : only present when EXEC_ALU_OVF_EN is defined
interface exec_alu_if
  import exec_pkg::*;
#(
  parameter int unsigned WIDTH = 32
);

  logic [WIDTH-1:0]    A;
  logic [WIDTH-1:0]    B;
  logic [ALU_OP_W-1:0] aluOp;
  logic [WIDTH-1:0]    R;
  logic                zero;
  logic [MD_OP_W-1:0]  mdOp;
  logic                start;
  logic                busy;
  logic [WIDTH-1:0]    hi;
  logic [WIDTH-1:0]    lo;
`ifdef EXEC_ALU_OVF_EN
  logic                ovf;
`endif

  modport master (
    output A, B, aluOp, mdOp, start,
    input  R, zero, busy, hi, lo
`ifdef EXEC_ALU_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  A, B, aluOp, mdOp, start,
    output R, zero, busy, hi, lo
`ifdef EXEC_ALU_OVF_EN
    , output ovf
`endif
  );

endinterface

// File: rtl/exec_md.sv
// exec_md: multi-cycle multiply/divide controller owning the HI/LO registers.
//   clk, reset_n         : clock, synchronous active-low reset
//   a_i, b_i, md_op_i    : operands and operation, latched on an accepted start
//   start_i              : single-cycle qualifier for md_op_i
//   busy_o               : high for MUL_CYCLES / DIV_CYCLES cycles after start
//   hi_o, lo_o           : HI/LO register contents
module exec_md
  import exec_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic [MD_OP_W-1:0] md_op_i,
  input  logic               start_i,
  output logic               busy_o,
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o
);

  localparam int unsigned MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int unsigned PW      = 2 * WIDTH;

  md_state_e          state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [MD_OP_W-1:0] op_q;
  logic               busy_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  // Result datapath, evaluated from the latched operands only.
  logic [PW-1:0]    prod_c;
  logic             sgn_mul_c;
  logic             sgn_div_c;
  logic             a_neg_c;
  logic             b_neg_c;
  logic [WIDTH-1:0] a_mag_c;
  logic [WIDTH-1:0] b_mag_c;
  logic [WIDTH-1:0] quo_mag_c;
  logic [WIDTH-1:0] rem_mag_c;
  logic [WIDTH-1:0] res_hi_c;
  logic [WIDTH-1:0] res_lo_c;
  logic             res_wr_c;

  assign sgn_mul_c = (op_q == MD_MULT);
  assign sgn_div_c = (op_q == MD_DIV);

  // Signed product via sign extension to 2*WIDTH; the low 2*WIDTH bits are exact.
  assign prod_c = {{WIDTH{sgn_mul_c & a_q[WIDTH-1]}}, a_q}
                * {{WIDTH{sgn_mul_c & b_q[WIDTH-1]}}, b_q};

  // Signed divide on magnitudes. MIN / -1 falls out naturally: |MIN| is 2^(W-1)
  // as an unsigned value, the quotient keeps sign bit set and the remainder is 0.
  assign a_neg_c   = sgn_div_c & a_q[WIDTH-1];
  assign b_neg_c   = sgn_div_c & b_q[WIDTH-1];
  assign a_mag_c   = a_neg_c ? (~a_q + WIDTH'(1)) : a_q;
  assign b_mag_c   = (b_q == '0) ? WIDTH'(1) : (b_neg_c ? (~b_q + WIDTH'(1)) : b_q);
  assign quo_mag_c = a_mag_c / b_mag_c;
  assign rem_mag_c = a_mag_c % b_mag_c;

  always_comb begin
    res_hi_c = prod_c[PW-1:WIDTH];
    res_lo_c = prod_c[WIDTH-1:0];
    res_wr_c = 1'b1;
    if (state_q == ST_DIV) begin
      res_lo_c = (a_neg_c ^ b_neg_c) ? (~quo_mag_c + WIDTH'(1)) : quo_mag_c;
      res_hi_c = a_neg_c ? (~rem_mag_c + WIDTH'(1)) : rem_mag_c;
      // Divide by zero still takes the full busy time but leaves HI/LO alone.
      res_wr_c = (b_q != '0);
    end
  end

  // Controller: starts are only honoured in IDLE, so a start while busy is dropped.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= MD_NONE;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            case (md_op_i)
              MD_MULT, MD_MULTU: begin
                state_q <= ST_MUL;
                cnt_q   <= CNT_W'(MUL_CYCLES - 1);
                busy_q  <= 1'b1;
                a_q     <= a_i;
                b_q     <= b_i;
                op_q    <= md_op_i;
              end
              MD_DIV, MD_DIVU: begin
                state_q <= ST_DIV;
                cnt_q   <= CNT_W'(DIV_CYCLES - 1);
                busy_q  <= 1'b1;
                a_q     <= a_i;
                b_q     <= b_i;
                op_q    <= md_op_i;
              end
              MD_MTHI: hi_q <= a_i;
              MD_MTLO: lo_q <= a_i;
              default: ;
            endcase
          end
        end
        ST_MUL, ST_DIV: begin
          if (cnt_q == '0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            if (res_wr_c) begin
              hi_q <= res_hi_c;
              lo_q <= res_lo_c;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: rtl/exec_alu.sv
// exec_alu: execute-stage combinational ALU plus multi-cycle multiply/divide (exec_md).
//   clk, reset_n : clock, synchronous active-low reset
//   bus (slave)  : A, B, aluOp -> R, zero (combinational)
//                  mdOp, start -> busy, hi, lo (registered, via exec_md)
// Build option: define EXEC_ALU_OVF_EN to add bus.ovf, the signed ADD/SUB overflow flag.
module exec_alu
  import exec_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  exec_alu_if.slave  bus
);

  localparam int unsigned SHW  = $clog2(WIDTH);
  localparam int unsigned HALF = WIDTH / 2;

  logic [SHW-1:0]   shamt_c;
  logic [WIDTH-1:0] sum_c;
  logic [WIDTH-1:0] diff_c;
  logic [WIDTH-1:0] r_c;

  assign shamt_c = bus.A[SHW-1:0];
  assign sum_c   = bus.A + bus.B;
  assign diff_c  = bus.A - bus.B;

  // Operation decode; undefined codes drive zero.
  always_comb begin
    r_c = '0;
    case (bus.aluOp)
      ALU_ADD:  r_c = sum_c;
      ALU_SUB:  r_c = diff_c;
      ALU_AND:  r_c = bus.A & bus.B;
      ALU_OR:   r_c = bus.A | bus.B;
      ALU_XOR:  r_c = bus.A ^ bus.B;
      ALU_NOR:  r_c = ~(bus.A | bus.B);
      ALU_SLT:  r_c = WIDTH'($signed(bus.A) < $signed(bus.B));
      ALU_SLTU: r_c = WIDTH'(bus.A < bus.B);
      ALU_SLL:  r_c = bus.B << shamt_c;
      ALU_SRL:  r_c = bus.B >> shamt_c;
      ALU_SRA:  r_c = WIDTH'($signed(bus.B) >>> shamt_c);
      ALU_LUI:  r_c = {bus.B[HALF-1:0], {HALF{1'b0}}};
      default:  r_c = '0;
    endcase
  end

  assign bus.R    = r_c;
  assign bus.zero = (bus.A == bus.B);

`ifdef EXEC_ALU_OVF_EN
  // Signed overflow: ADD when like-signed operands give a differently signed sum,
  // SUB when unlike-signed operands give a result whose sign differs from A.
  logic add_ovf_c;
  logic sub_ovf_c;

  assign add_ovf_c = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum_c[WIDTH-1]  != bus.A[WIDTH-1]);
  assign sub_ovf_c = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff_c[WIDTH-1] != bus.A[WIDTH-1]);

  always_comb begin
    bus.ovf = 1'b0;
    if (bus.aluOp == ALU_ADD) bus.ovf = add_ovf_c;
    else if (bus.aluOp == ALU_SUB) bus.ovf = sub_ovf_c;
  end
`endif

  exec_md #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md (
    .clk     (clk),
    .reset_n (reset_n),
    .a_i     (bus.A),
    .b_i     (bus.B),
    .md_op_i (bus.mdOp),
    .start_i (bus.start),
    .busy_o  (bus.busy),
    .hi_o    (bus.hi),
    .lo_o    (bus.lo)
  );

endmodule

// File: tb/tb_exec_alu.sv
// tb_exec_alu: directed vectors for exec_alu (WIDTH=32, MUL_CYCLES=5, DIV_CYCLES=10).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_exec_alu;

  logic clk;
  logic reset_n;
  int   vectors;
  int   miscompares;
  int   n;

  exec_alu_if #(.WIDTH(32)) bus ();

  exec_alu #(
    .WIDTH      (32),
    .MUL_CYCLES (5),
    .DIV_CYCLES (10)
  ) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Counts remaining busy cycles; a stuck busy gives 40 and miscompares.
  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
  endtask

  task automatic alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.aluOp = op;
    bus.A     = a;
    bus.B     = b;
    #1;
  endtask

  task automatic md_start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.mdOp  = op;
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.mdOp  = 3'd0;
    bus.A     = 32'hDEAD_BEEF;
    bus.B     = 32'h0000_0003;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    bus.A       = '0;
    bus.B       = '0;
    bus.aluOp   = '0;
    bus.mdOp    = '0;
    bus.start   = 1'b0;
    tick();
    tick();
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_hi",   64'(bus.hi),   64'd0);
    chk("reset_lo",   64'(bus.lo),   64'd0);
    reset_n = 1'b1;
    tick();

    // Combinational ALU
    alu(4'd0, 32'h7FFF_FFFF, 32'h0000_0001);
    chk("add_ovf_r", 64'(bus.R), 64'h8000_0000);
`ifdef EXEC_ALU_OVF_EN
    chk("add_ovf_flag", 64'(bus.ovf), 64'd1);
`endif
    alu(4'd1, 32'h0000_0005, 32'h0000_0007);
    chk("sub_r", 64'(bus.R), 64'hFFFF_FFFE);
    alu(4'd1, 32'h8000_0000, 32'h0000_0001);
    chk("sub_wrap_r", 64'(bus.R), 64'h7FFF_FFFF);
`ifdef EXEC_ALU_OVF_EN
    chk("sub_ovf_flag", 64'(bus.ovf), 64'd1);
`endif
    alu(4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00);
    chk("and_r", 64'(bus.R), 64'hF000_F000);
`ifdef EXEC_ALU_OVF_EN
    chk("and_no_ovf", 64'(bus.ovf), 64'd0);
`endif
    alu(4'd3, 32'hF0F0_F0F0, 32'hFF00_FF00);
    chk("or_r", 64'(bus.R), 64'hFFF0_FFF0);
    alu(4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00);
    chk("xor_r", 64'(bus.R), 64'h0FF0_0FF0);
    alu(4'd5, 32'hF0F0_F0F0, 32'hFF00_FF00);
    chk("nor_r", 64'(bus.R), 64'h000F_000F);
    alu(4'd6, 32'hFFFF_FFFF, 32'h0000_0001);
    chk("slt_r", 64'(bus.R), 64'd1);
    alu(4'd7, 32'hFFFF_FFFF, 32'h0000_0001);
    chk("sltu_r", 64'(bus.R), 64'd0);
    alu(4'd8, 32'h0000_0024, 32'h0000_0003);
    chk("sll_r", 64'(bus.R), 64'h0000_0030);
    alu(4'd9, 32'h0000_0004, 32'h8000_0000);
    chk("srl_r", 64'(bus.R), 64'h0800_0000);
    alu(4'd10, 32'h0000_0004, 32'h8000_0000);
    chk("sra_r", 64'(bus.R), 64'hF800_0000);
    alu(4'd11, 32'h0000_0000, 32'h1234_ABCD);
    chk("lui_r", 64'(bus.R), 64'hABCD_0000);
    alu(4'd13, 32'h1234_5678, 32'h8765_4321);
    chk("undef_r", 64'(bus.R), 64'd0);
    chk("zero_ne", 64'(bus.zero), 64'd0);
    alu(4'd0, 32'h5A5A_5A5A, 32'h5A5A_5A5A);
    chk("zero_eq", 64'(bus.zero), 64'd1);

    // MULT -3 * 7
    md_start(3'd1, 32'hFFFF_FFFD, 32'h0000_0007);
    wait_idle(n);
    chk("mult_busy_cycles", 64'(n), 64'd5);
    chk("mult_hi", 64'(bus.hi), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(bus.lo), 64'hFFFF_FFEB);

    // DIV -7 / 2
    md_start(3'd3, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_idle(n);
    chk("div_busy_cycles", 64'(n), 64'd10);
    chk("div_lo", 64'(bus.lo), 64'hFFFF_FFFD);
    chk("div_hi", 64'(bus.hi), 64'hFFFF_FFFF);

    // DIVU by zero keeps HI/LO
    md_start(3'd4, 32'h0000_0009, 32'h0000_0000);
    wait_idle(n);
    chk("divz_busy_cycles", 64'(n), 64'd10);
    chk("divz_lo", 64'(bus.lo), 64'hFFFF_FFFD);
    chk("divz_hi", 64'(bus.hi), 64'hFFFF_FFFF);

    // DIV most-negative / -1
    md_start(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    chk("divmin_lo", 64'(bus.lo), 64'h8000_0000);
    chk("divmin_hi", 64'(bus.hi), 64'h0000_0000);

    // MULTU with an MTLO start during busy cycle 2 (ignored)
    md_start(3'd2, 32'hFFFF_FFFF, 32'h0000_0002);
    tick();
    bus.mdOp  = 3'd6;
    bus.A     = 32'h0000_0055;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.mdOp  = 3'd0;
    wait_idle(n);
    chk("multu_rest_cycles", 64'(n), 64'd3);
    chk("multu_hi", 64'(bus.hi), 64'h0000_0001);
    chk("multu_lo", 64'(bus.lo), 64'hFFFF_FFFE);

    // MTHI, then NONE / reserved starts
    md_start(3'd5, 32'h1234_5678, 32'h0);
    chk("mthi_busy", 64'(bus.busy), 64'd0);
    chk("mthi_hi", 64'(bus.hi), 64'h1234_5678);
    md_start(3'd0, 32'hAAAA_AAAA, 32'h0);
    md_start(3'd7, 32'hBBBB_BBBB, 32'h0);
    chk("none_busy", 64'(bus.busy), 64'd0);
    chk("none_hi", 64'(bus.hi), 64'h1234_5678);
    chk("none_lo", 64'(bus.lo), 64'hFFFF_FFFE);

    // Reset during DIV busy cycle 3, then reset beating a start
    md_start(3'd3, 32'h0000_0064, 32'h0000_0007);
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    md_start(3'd1, 32'h0000_0003, 32'h0000_0003);
    chk("rst_prio_busy", 64'(bus.busy), 64'd0);
    reset_n = 1'b1;
    md_start(3'd5, 32'h0000_0005, 32'h0);
    chk("post_rst_mthi", 64'(bus.hi), 64'h0000_0005);
    chk("post_rst_busy", 64'(bus.busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/exec_alu.md
EXEC_ALU -- requirements
Module: exec_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width (>=8, power of 2).
REQ-002 SHALL have parameter MUL_CYCLES, default 5, multiply busy duration in cycles (>=1).
REQ-003 SHALL have parameter DIV_CYCLES, default 10, divide busy duration in cycles (>=1).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have ports A, B  input  WIDTH  operands.
REQ-007 SHALL have port aluOp  input  4  combinational operation select.
REQ-008 SHALL have port R  output  WIDTH  combinational result.
REQ-009 SHALL have port zero  output  1  high when A == B.
REQ-010 SHALL have port mdOp  input  3  multiply/divide op: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (NONE).
REQ-011 SHALL have port start  input  1  single-cycle mdOp qualifier.
REQ-012 SHALL have port busy  output  1  multi-cycle operation in flight.
REQ-013 SHALL have ports hi, lo  output  WIDTH  registered HI/LO contents.

Function
REQ-014 aluOp SHALL decode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed), 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 LUI; add/sub wrap modulo 2^WIDTH.
REQ-015 Shifts SHALL shift B by A[$clog2(WIDTH)-1:0]; LUI SHALL give {B[WIDTH/2-1:0], WIDTH/2 zeros}.
REQ-016 Undefined aluOp (12-15) SHALL give R = 0; R never holds state (no latch).
REQ-017 SLT/SLTU SHALL give R = 1 or 0, zero-extended.
REQ-018 MD control SHALL be FSM IDLE, MUL, DIV with down-counter; IDLE->MUL on start & MULT/MULTU, IDLE->DIV on start & DIV/DIVU.
REQ-019 At start in IDLE, A, B, op SHALL be latched; later operand changes SHALL not affect result.
REQ-020 busy SHALL be high exactly MUL_CYCLES (or DIV_CYCLES) cycles, starting the cycle after start.
REQ-021 hi/lo SHALL update on the clock edge where busy falls; MUL: {hi,lo} = 2*WIDTH product.
REQ-022 DIV: lo = quotient truncated toward zero, hi = remainder with dividend sign; DIV of most-negative by -1: lo = most-negative, hi = 0.
REQ-023 Divide by zero SHALL run full DIV_CYCLES and leave hi/lo unchanged.
REQ-024 MTHI/MTLO with start in IDLE SHALL write A to hi/lo on that edge, busy stays low.
REQ-025 Any start while busy SHALL be ignored (no state, counter or hi/lo change).
REQ-026 start with mdOp NONE/reserved SHALL have no effect.

Reset
REQ-027 reset_n low at an edge SHALL force IDLE, counter 0, busy 0, hi 0, lo 0; mid-operation result discarded.
REQ-028 reset_n SHALL take priority over start in the same cycle.

Configuration
REQ-029 With EXEC_ALU_OVF_EN defined, output ovf (1 bit) SHALL be high when aluOp is ADD or SUB and signed overflow occurs, else low.
REQ-030 Without EXEC_ALU_OVF_EN, port ovf SHALL not exist; all other behaviour identical.

Structure
REQ-031 Package exec_pkg SHALL hold aluOp and mdOp encodings and the MD state typedef.
REQ-032 Multiply/divide FSM, counter and hi/lo SHALL be sub-module exec_md; ALU decode stays in exec_alu.

Verification
REQ-033 WIDTH=32, A=0x7FFFFFFF, B=1, aluOp ADD -> R=0x80000000; ovf=1 when EXEC_ALU_OVF_EN defined.
REQ-034 aluOp SRA, A=4, B=0x80000000 -> R=0xF8000000; aluOp 13 -> R=0.
REQ-035 MULT start, A=-3, B=7 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-036 DIV start, A=-7, B=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU by 0 -> hi/lo unchanged.
REQ-037 MULTU started, MTLO with start at busy cycle 2 -> ignored; lo = product low word.
REQ-038 reset_n low during busy cycle 3 of DIV -> next cycle busy=0, hi=lo=0; following MTHI A=5 -> hi=5.
